mux_scan_ctrl: RTL and testbench

Sequencing controller that sits around the 16:1 bit multiplexer: drives its 4-bit select through every input in turn, samples the single-bit mux output each step, and reassembles the bits into a parallel word. Turns the combinational mux into a registered 16-bit parallel-capture path with a start/done handshake. Single clock domain; the mux is purely combinational between `sel` and `mux_out`.

---
 rtl/mux_scan_ctrl.sv | 86 ++++++++
 tb/tb_mux_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Walks a 16:1 bit mux select through every input and reassembles the samples into a parallel word.
// Latency: WIDTH cycles per scan, or 2*WIDTH with MUX_SCAN_SETTLE_EN (extra settle cycle per step).
// No backpressure: start is taken in IDLE only; done is a single-cycle pulse with word held until the next one.
module mux_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] word
);

`ifdef MUX_SCAN_SETTLE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SETTLE = 2'd2} state_t;
  localparam state_t STEP_ST = SETTLE;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
  localparam state_t STEP_ST = SCAN;
`endif

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic [WIDTH-1:0] cap, cap_nxt;
  logic [WIDTH-1:0] word_nxt;
  logic             done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      cap   <= '0;
      word  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cap   <= cap_nxt;
      word  <= word_nxt;
      done  <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    cap_nxt   = cap;
    word_nxt  = word;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          sel_nxt   = '0;
          state_nxt = STEP_ST;
        end
      end
`ifdef MUX_SCAN_SETTLE_EN
      SETTLE: state_nxt = SCAN;
`endif
      SCAN: begin
        cap_nxt[sel] = mux_out;
        if (sel == SEL_LAST) begin
          // word takes the bit sampled on this same edge
          word_nxt  = cap_nxt;
          done_nxt  = 1'b1;
          sel_nxt   = '0;
          state_nxt = cont ? STEP_ST : IDLE;
        end else begin
          sel_nxt   = sel + 1'b1;
          state_nxt = STEP_ST;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: a cycle-count model of the scan timing checked every cycle, plus directed literal checks.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_SETTLE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int W = 16;
  localparam int P = W * STEP;

  logic        clk, rst, start, cont, mux_out;
  logic [3:0]  sel;
  logic        busy, done;
  logic [15:0] word;
  logic [15:0] mux_in;

  int vectors = 0;
  int fails   = 0;

  mux_scan_ctrl #(.WIDTH(W), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_out(mux_out),
    .sel(sel), .busy(busy), .done(done), .word(word)
  );

  assign mux_out = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a scan is P edges long; every STEP-th edge samples the next bit.
  bit          m_active = 1'b0;
  int          m_cnt    = 0;
  logic [15:0] m_cap    = '0;
  logic [15:0] m_word   = '0;
  bit          m_done   = 1'b0;

  always @(posedge clk or posedge rst) begin
    int t;
    if (rst) begin
      m_active = 1'b0; m_cnt = 0; m_cap = '0; m_word = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          m_cnt    = 0;
        end
      end else begin
        t = m_cnt + 1;
        if (t % STEP == 0) m_cap[t/STEP-1] = mux_in[t/STEP-1];
        if (t == P) begin
          m_word   = m_cap;
          m_done   = 1'b1;
          m_cnt    = 0;
          m_active = cont;
        end else begin
          m_cnt = t;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model sel",  32'(sel),  m_active ? 32'(m_cnt / STEP) : 32'd0);
    check("model busy", 32'(busy), 32'(m_active));
    check("model done", 32'(done), 32'(m_done));
    check("model word", 32'(word), 32'(m_word));
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < limit);
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_sel(input int target, input int limit, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel !== 4'(target) && n < limit);
    check(name, 32'(sel), 32'(target));
  endtask

  task automatic count_dones(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1) c++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n, c, first, ndone;
    rst = 1'b0; start = 1'b0; cont = 1'b0; mux_in = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset sel",  32'(sel),  32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset word", 32'(word), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic scan
    mux_in = 16'h3f1a;
    pulse_start();
    check("basic busy after start", 32'(busy), 32'd1);
    wait_done(P + 5, "basic done seen", n);
    check("basic latency", 32'(n), 32'(P));
    check("basic word", 32'(word), 32'h3f1a);
    check("basic busy at done", 32'(busy), 32'd0);
    check("basic sel at done", 32'(sel), 32'd0);
    count_dones(P + 4, c);
    check("basic single done", 32'(c), 32'd0);

    // Back-to-back continuous scans
    mux_in = 16'h11ad;
    cont = 1'b1;
    pulse_start();
    wait_done(P + 5, "b2b first done", n);
    check("b2b first word", 32'(word), 32'h11ad);
    mux_in = 16'h10bd;
    wait_done(P + 5, "b2b second done", n);
    check("b2b period", 32'(n), 32'(P));
    check("b2b second word", 32'(word), 32'h10bd);
    check("b2b busy held", 32'(busy), 32'd1);
    cont = 1'b0;
    wait_done(P + 5, "b2b third done", n);
    check("b2b busy drop", 32'(busy), 32'd0);
    count_dones(P + 4, c);
    check("b2b no extra done", 32'(c), 32'd0);

    // Start held while busy
    mux_in = 16'habcd;
    start = 1'b1;
    first = -1; ndone = 0;
    for (int k = 1; k <= 3 * P; k++) begin
      @(negedge clk);
      if (k == 20) start = 1'b0;
      if (first >= 0 && k == first + 1) check("held restart busy", 32'(busy), 32'(P < 20));
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = k;
          check("held word", 32'(word), 32'habcd);
          check("held busy at done", 32'(busy), 32'd0);
        end
      end
    end
    check("held first done cycle", 32'(first), 32'(P + 1));
    check("held done count", 32'(ndone), 32'(1 + (P < 20)));

    // Asynchronous reset mid-scan
    mux_in = 16'hffff;
    pulse_start();
    wait_sel(7, P, "rst reached sel 7");
    #2 rst = 1'b1;
    #1;
    check("async rst sel",  32'(sel),  32'd0);
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst done", 32'(done), 32'd0);
    check("async rst word", 32'(word), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    count_dones(P + 4, c);
    check("rst no done", 32'(c), 32'd0);
    mux_in = 16'h1111;
    pulse_start();
    wait_done(P + 5, "post-rst done", n);
    check("post-rst word", 32'(word), 32'h1111);

    // Input change mid-scan
    mux_in = 16'h0000;
    pulse_start();
    wait_sel(8, P, "midchg reached sel 8");
    mux_in = 16'hfad0;
    wait_done(P + 5, "midchg done", n);
    check("midchg word", 32'(word), 32'hfa00);

    // Cont dropped during the second scan
    mux_in = 16'h5a5a;
    cont = 1'b1;
    pulse_start();
    wait_done(P + 5, "contdrop first done", n);
    check("contdrop first word", 32'(word), 32'h5a5a);
    mux_in = 16'h0ff0;
    repeat (P / 2) @(negedge clk);
    cont = 1'b0;
    wait_done(P + 5, "contdrop second done", n);
    check("contdrop second word", 32'(word), 32'h0ff0);
    check("contdrop idle", 32'(busy), 32'd0);
    count_dones(2 * P + 4, c);
    check("contdrop no third done", 32'(c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
